// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer for the single-issue datapath.
// Optional MEM wait timeout with MEM_ERR pulse, enabled by defining CTRL_MEM_TIMEOUT_EN.
//
//  state  | meaning
//  IDLE   | parked, waiting for RUN
//  FETCH  | load IR from combinational IMEM, bump PC
//  DECODE | latch opcode class; J and illegal finish here
//  EXEC   | ALU operates (funct or add)
//  MEM    | data-memory access, waits on MEM_READY
//  WB     | register-bank write from ALU or memory
module multicycle_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RUN,
  input  logic [4:0] OPCODE,
  input  logic       MEM_READY,
  output logic       IR_LD,
  output logic       PC_INC,
  output logic       PC_JMP,
  output logic       WE,
  output logic       MEM2REG,
  output logic       W,
  output logic       R,
  output logic [1:0] ALUOP,
  output logic       BUSY,
  output logic       ILLEGAL,
  output logic       MEM_ERR
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_J, CLS_ILL
  } cls_t;

  state_t state_q, state_d, next_st;
  cls_t   cls_q, cls_d, op_cls;
  logic   illegal_q, illegal_d;
  logic   mem_tmo;

  always_comb begin
    case (OPCODE)
      5'b00000: op_cls = CLS_R;
      5'b00001: op_cls = CLS_I;
      5'b00010: op_cls = CLS_LW;
      5'b00011: op_cls = CLS_SW;
      5'b00100: op_cls = CLS_J;
      default:  op_cls = CLS_ILL;
    endcase
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // MEM_READY on the last allowed cycle takes priority over the abort
  assign mem_tmo = (state_q == ST_MEM) && !MEM_READY &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_MEM) && !MEM_READY && !mem_tmo)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYC, CNT_W};
  assign mem_tmo    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  assign next_st = RUN ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:   if (RUN) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d = op_cls;
        case (op_cls)
          CLS_J:   state_d = next_st;
          CLS_ILL: begin
            illegal_d = 1'b1;
            state_d   = next_st;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC:   state_d = ((cls_q == CLS_LW) || (cls_q == CLS_SW)) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (MEM_READY)    state_d = (cls_q == CLS_LW) ? ST_WB : next_st;
        else if (mem_tmo) state_d = next_st;
      end
      ST_WB:     state_d = next_st;
      default:   state_d = ST_IDLE;
    endcase
  end

  // DECODE strobes come straight from OPCODE: the class is only latched as DECODE ends
  always_comb begin
    IR_LD   = 1'b0;
    PC_INC  = 1'b0;
    PC_JMP  = 1'b0;
    WE      = 1'b0;
    MEM2REG = 1'b0;
    W       = 1'b0;
    R       = 1'b0;
    ALUOP   = 2'b00;
    BUSY    = (state_q != ST_IDLE);
    case (state_q)
      ST_FETCH: begin
        IR_LD  = 1'b1;
        PC_INC = 1'b1;
      end
      ST_DECODE: begin
        if (op_cls == CLS_J) begin
          PC_JMP = 1'b1;
          ALUOP  = 2'b01;
        end
      end
      ST_EXEC:  ALUOP = (cls_q == CLS_R) ? 2'b10 : 2'b00;
      ST_MEM: begin
        R = (cls_q == CLS_LW);
        W = (cls_q == CLS_SW);
      end
      ST_WB: begin
        WE      = 1'b1;
        MEM2REG = (cls_q == CLS_LW);
      end
      default: ;
    endcase
  end

  assign ILLEGAL = illegal_q;
  assign MEM_ERR = mem_tmo;

endmodule
